// File: rtl/uart_tx_periph_pkg.sv
// Shared register map, status bit positions and serialiser state encoding
// for the UART0 transmitter peripheral.
package uart_tx_periph_pkg;

   localparam logic UART_REG_DATA   = 1'b0;
   localparam logic UART_REG_STATUS = 1'b1;

   localparam int STATUS_IDLE_BIT = 1;
   localparam int STATUS_FULL_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Nearest-integer clock divider for one bit time.
   function automatic int calc_div(input int f_clk, input int baud);
      return (f_clk + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Small synchronous FIFO with occupancy count; a push while full is only
// accepted when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART0 transmitter: DATA/STATUS bus slave, TX FIFO and an
// 8N1 serialiser driving a registered, idle-high tx pin.
module uart_tx_periph
   import uart_tx_periph_pkg::*;
#(
   parameter int F_CLK      = 12000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        bus_sel,
   input  logic        bus_adr,
   input  logic [3:0]  bus_wren,
   input  logic [31:0] bus_di,
   output logic [31:0] bus_do,
   output logic        tx
);

   localparam int DIV    = calc_div(F_CLK, BAUD);
   localparam int CNT_W  = $clog2(DIV);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   tx_state_t         state, state_nxt;
   logic [CNT_W-1:0]  baud_cnt, cnt_nxt;
   logic [2:0]        bit_idx, bit_nxt;
   logic [7:0]        shreg, shreg_nxt;
   logic              tx_nxt;

   logic              fifo_push;
   logic              fifo_pop;
   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic [31:0]       status_word;
   logic              unused_di;

   assign unused_di = ^bus_di[31:8];
   assign fifo_push = bus_sel && (bus_adr == UART_REG_DATA) && bus_wren[0];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .din     (bus_di[7:0]),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      status_word                  = '0;
      status_word[STATUS_IDLE_BIT] = (state == ST_IDLE) && (fifo_count == '0);
      status_word[STATUS_FULL_BIT] = fifo_full;
   end

   // Reads capture on the access edge; the value holds until the next read.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bus_do <= '0;
      end else if (bus_sel && (bus_wren == 4'b0000)) begin
         bus_do <= (bus_adr == UART_REG_STATUS) ? status_word : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= 8'hFF;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= cnt_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         tx       <= tx_nxt;
      end
   end

   // The baud counter restarts on every state entry, so each state lasts DIV clocks.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = baud_cnt + 1'b1;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shreg_nxt = fifo_dout;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (baud_cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               shreg_nxt = {1'b1, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = ST_STOP;
               else                 bit_nxt   = bit_idx + 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // tx is decoded from the next state so the pin itself comes straight off a flop.
      case (state_nxt)
         ST_START: tx_nxt = 1'b0;
         ST_DATA:  tx_nxt = shreg_nxt[0];
         default:  tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed/randomised bench for uart_tx_periph: a line monitor decodes 8N1
// frames from tx and expected bytes/start times come from frame arithmetic.
module tb_uart_tx_periph;

   localparam int F_CLK = 1000000;
   localparam int BAUD  = 100000;
   localparam int DIV   = 10;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * DIV;

   logic        clk      = 1'b0;
   logic        n_reset  = 1'b0;
   logic        bus_sel  = 1'b0;
   logic        bus_adr  = 1'b0;
   logic [3:0]  bus_wren = 4'b0000;
   logic [31:0] bus_di   = 32'd0;
   logic [31:0] bus_do;
   logic        tx;

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;
   int rst_count  = 0;
   int tx_low_cnt = 0;

   byte unsigned rx_q[$];
   int           rx_t[$];
   bit           rx_ok[$];
   int           rx_rd = 0;
   byte unsigned stim_q[$];

   int         mon_t0;
   int         mon_rc;
   bit         mon_ok;
   logic [7:0] mon_b;

   uart_tx_periph #(
      .F_CLK      (F_CLK),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .bus_sel  (bus_sel),
      .bus_adr  (bus_adr),
      .bus_wren (bus_wren),
      .bus_di   (bus_di),
      .bus_do   (bus_do),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge n_reset) rst_count++;
   always @(negedge clk) if (n_reset === 1'b1 && tx === 1'b0) tx_low_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Line monitor: samples mid-bit and drops any frame interrupted by reset.
   initial begin
      forever begin
         @(negedge clk);
         if (n_reset === 1'b1 && tx === 1'b0) begin
            mon_t0 = cyc;
            mon_rc = rst_count;
            mon_ok = 1'b1;
            repeat (DIV / 2 - 1) @(negedge clk);
            if (tx !== 1'b0) mon_ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
               repeat (DIV) @(negedge clk);
               mon_b[k] = tx;
            end
            repeat (DIV) @(negedge clk);
            if (tx !== 1'b1) mon_ok = 1'b0;
            if (rst_count == mon_rc) begin
               rx_q.push_back(mon_b);
               rx_t.push_back(mon_t0);
               rx_ok.push_back(mon_ok);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_to(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic bus_wr(input logic adr, input logic [3:0] wren, input logic [7:0] d,
                         output int w);
      @(negedge clk);
      bus_sel  = 1'b1;
      bus_adr  = adr;
      bus_wren = wren;
      bus_di   = {24'($urandom()), d};
      @(posedge clk);
      #1;
      w        = cyc;
      bus_sel  = 1'b0;
      bus_wren = 4'b0000;
   endtask

   task automatic bus_rd(input logic adr, output logic [31:0] v);
      @(negedge clk);
      bus_sel  = 1'b1;
      bus_adr  = adr;
      bus_wren = 4'b0000;
      @(posedge clk);
      #1;
      bus_sel  = 1'b0;
      @(negedge clk);
      v = bus_do;
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int lim;
      lim = cyc + budget;
      while (rx_q.size() < target && cyc < lim) @(negedge clk);
      chk(tag, 32'(rx_q.size()), 32'(target));
   endtask

   task automatic pop_frame(input string tag, input logic [7:0] b, input int t);
      if (rx_rd < rx_q.size()) begin
         chk({tag, "_byte"},  32'(rx_q[rx_rd]), 32'(b));
         chk({tag, "_start"}, 32'(rx_t[rx_rd]), 32'(t));
         chk({tag, "_frame"}, 32'(rx_ok[rx_rd]), 32'd1);
         rx_rd++;
      end
   endtask

   // Back-to-back bytes into an idle transmitter: start edges 101 clocks apart.
   task automatic run_burst(input string tag);
      int w;
      int w0;
      int t_last;
      int n;
      logic [31:0] v;
      n  = stim_q.size();
      w0 = 0;
      foreach (stim_q[i]) begin
         bus_wr(1'b0, 4'b0001, stim_q[i], w);
         if (i == 0) w0 = w;
      end
      wait_frames(rx_rd + n, n * (FRAME + 1) + 50, {tag, "_count"});
      foreach (stim_q[i]) pop_frame(tag, stim_q[i], w0 + 1 + i * (FRAME + 1));
      t_last = w0 + 1 + (n - 1) * (FRAME + 1);
      wait_to(t_last + FRAME);
      bus_rd(1'b1, v);
      chk({tag, "_status_end"}, v, 32'd2);
   endtask

   initial begin
      int w;
      int t0;
      int low0;
      int b61;
      logic [7:0] pre;
      logic [31:0] v;

      // Reset and idle line
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_bus_do", bus_do, 32'd0);
      n_reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_tx_const", 32'(tx_low_cnt), 32'd0);
      bus_rd(1'b1, v);
      chk("status_idle", v, 32'd2);
      repeat (3) @(negedge clk);
      chk("rd_hold", bus_do, 32'd2);
      bus_rd(1'b0, v);
      chk("data_reads_zero", v, 32'd0);

      // Single 0x61 frame with exact status timing
      bus_wr(1'b0, 4'b0001, 8'h61, w);
      t0 = w + 1;
      bus_rd(1'b1, v);
      chk("push_visible", v, 32'd0);
      wait_to(t0 + 48);
      bus_rd(1'b1, v);
      chk("status_busy", v, 32'd0);
      wait_to(t0 + FRAME - 1);
      bus_sel  = 1'b1;
      bus_adr  = 1'b1;
      bus_wren = 4'b0000;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("status_last_stop_clk", bus_do, 32'd0);
      @(posedge clk);
      #1;
      bus_sel = 1'b0;
      @(negedge clk);
      chk("status_after_frame", bus_do, 32'd2);
      wait_frames(rx_rd + 1, 50, "f61_count");
      pop_frame("f61", 8'h61, t0);

      // Four back-to-back bytes, then random bursts
      stim_q = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
      run_burst("b2b");
      for (int r = 0; r < 3; r++) begin
         stim_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 5)); i++) stim_q.push_back(8'($urandom()));
         if (stim_q.size() == 0) stim_q.push_back(8'($urandom()));
         run_burst("rand");
      end

      // Overflow: shifter busy, five writes, fifth dropped
      pre = 8'($urandom());
      bus_wr(1'b0, 4'b0001, pre, w);
      t0 = w + 1;
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 4; i++) bus_wr(1'b0, 4'b0001, 8'(i), w);
      bus_rd(1'b1, v);
      chk("full_after_4", v, 32'd1);
      bus_wr(1'b0, 4'b0001, 8'h05, w);
      bus_rd(1'b1, v);
      chk("full_after_5", v, 32'd1);
      wait_frames(rx_rd + 5, 5 * (FRAME + 1) + 50, "ovf_count");
      pop_frame("ovf_pre", pre, t0);
      for (int i = 0; i < 4; i++) pop_frame("ovf", 8'(i + 1), t0 + (i + 1) * (FRAME + 1));
      wait_to(cyc + 2 * FRAME);
      chk("ovf_no_fifth", 32'(rx_q.size()), 32'(rx_rd));
      bus_rd(1'b1, v);
      chk("ovf_status_end", v, 32'd2);

      // Reset in the middle of a frame with another byte queued
      bus_wr(1'b0, 4'b0001, 8'h61, w);
      t0 = w + 1;
      bus_wr(1'b0, 4'b0001, 8'h33, w);
      wait_to(t0 + 35);
      b61 = 'h61;
      chk("mid_frame_bit", 32'(tx), 32'((b61 >> ((35 - DIV) / DIV)) & 1));
      #1 n_reset = 1'b0;
      #1;
      chk("async_rst_tx", 32'(tx), 32'd1);
      chk("async_rst_bus_do", bus_do, 32'd0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      low0 = tx_low_cnt;
      wait_to(cyc + 3 * FRAME);
      chk("rst_no_frames", 32'(rx_q.size()), 32'(rx_rd));
      chk("rst_line_high", 32'(tx_low_cnt), 32'(low0));
      bus_rd(1'b1, v);
      chk("rst_status", v, 32'd2);

      // Ignored writes: upper byte enables only, and STATUS offset
      low0 = tx_low_cnt;
      bus_wr(1'b0, 4'b1110, 8'($urandom()), w);
      bus_wr(1'b1, 4'b0001, 8'($urandom()), w);
      bus_wr(1'b1, 4'b1111, 8'($urandom()), w);
      bus_rd(1'b1, v);
      chk("ign_status_now", v, 32'd2);
      wait_to(cyc + 150);
      chk("ign_no_frames", 32'(rx_q.size()), 32'(rx_rd));
      chk("ign_line_high", 32'(tx_low_cnt), 32'(low0));
      bus_rd(1'b1, v);
      chk("ign_status_end", v, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
